// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared encodings for the load/store/writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 32;

    localparam logic [1:0] OP_ALU   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } lsu_state_e;

    // funct3[2] only selects signedness; the low bits carry the access size.
    function automatic logic [1:0] f3_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   f3_size = SZ_B;
            2'b01:   f3_size = SZ_H;
            default: f3_size = SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Selects the addressed byte/half lane of a load word and extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_signed = !funct3[2];
    assign w_half   = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        w_byte = rdata[7:0];
        case (lane)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
    end

    always_comb begin
        data = rdata;
        case (f3_size(funct3))
            SZ_B:    data = {{(XLEN-8){w_signed && w_byte[7]}}, w_byte};
            SZ_H:    data = {{(XLEN-16){w_signed && w_half[15]}}, w_half};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store and writeback stage; sole register-file writer.
//            Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_lsu_vld,
    output logic            lsu_exu_rdy,
    input  logic [1:0]      exu_lsu_op,
    input  logic [2:0]      exu_lsu_funct3,
    input  logic [AW-1:0]   exu_lsu_addr,
    input  logic [XLEN-1:0] exu_lsu_data,
    input  logic [4:0]      exu_lsu_rd,
    output logic            lsu_dmem_req_vld,
    input  logic            dmem_lsu_req_rdy,
    output logic            lsu_dmem_we,
    output logic [AW-1:0]   lsu_dmem_addr,
    output logic [3:0]      lsu_dmem_wstrb,
    output logic [XLEN-1:0] lsu_dmem_wdata,
    input  logic            dmem_lsu_rsp_vld,
    input  logic [XLEN-1:0] dmem_lsu_rdata,
    output logic            lsu_rf_wb_vld,
    output logic [4:0]      lsu_rf_wb_addr,
    output logic [XLEN-1:0] lsu_rf_wb_data,
    output logic            lsu_exc_vld
);

    lsu_state_e      r_state;
    lsu_state_e      w_state_nxt;

    logic            w_accept;
    logic            w_is_mem;
    logic            w_trap;
    logic            w_start;
    logic [1:0]      w_size;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;

    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;

    logic            r_wb_vld;
    logic [4:0]      r_wb_addr;
    logic [XLEN-1:0] r_wb_data;

    assign w_accept = exu_lsu_vld && (r_state == ST_IDLE);
    assign w_size   = f3_size(exu_lsu_funct3);
    assign w_is_mem = w_accept && (exu_lsu_op == OP_LOAD || exu_lsu_op == OP_STORE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_exc_vld;

    assign w_trap = w_is_mem &&
                    ((w_size == SZ_H && exu_lsu_addr[0]) ||
                     (w_size == SZ_W && exu_lsu_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_exc_vld <= 1'b0;
        else     r_exc_vld <= w_trap;
    end

    assign lsu_exc_vld = r_exc_vld;
`else
    // Without the trap, low address bits below natural alignment are simply
    // ignored by the strobe and lane logic.
    assign w_trap      = 1'b0;
    assign lsu_exc_vld = 1'b0;
`endif

    assign w_start = w_is_mem && !w_trap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        lsu_exu_rdy      = 1'b0;
        lsu_dmem_req_vld = 1'b0;
        case (r_state)
            ST_IDLE: begin
                lsu_exu_rdy = 1'b1;
                if (w_start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                lsu_dmem_req_vld = 1'b1;
                if (dmem_lsu_req_rdy) w_state_nxt = r_we ? ST_IDLE : ST_RSP;
            end
            ST_RSP: begin
                if (dmem_lsu_rsp_vld) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = exu_lsu_data;
        case (w_size)
            SZ_B: begin
                w_wstrb = 4'b0001 << exu_lsu_addr[1:0];
                w_wdata = {(XLEN/8){exu_lsu_data[7:0]}};
            end
            SZ_H: begin
                w_wstrb = exu_lsu_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(XLEN/16){exu_lsu_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Request fields are frozen at accept so they stay stable while REQ waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wstrb  <= 4'b0000;
            r_wdata  <= '0;
            r_rd     <= 5'd0;
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
        end else if (w_start) begin
            r_we     <= (exu_lsu_op == OP_STORE);
            r_addr   <= {exu_lsu_addr[AW-1:2], 2'b00};
            r_wstrb  <= w_wstrb;
            r_wdata  <= w_wdata;
            r_rd     <= exu_lsu_rd;
            r_funct3 <= exu_lsu_funct3;
            r_lane   <= exu_lsu_addr[1:0];
        end
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata  (dmem_lsu_rdata),
        .lane   (r_lane),
        .funct3 (r_funct3),
        .data   (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_vld  <= 1'b0;
            r_wb_addr <= 5'd0;
            r_wb_data <= '0;
        end else begin
            r_wb_vld <= 1'b0;
            if (w_accept && exu_lsu_op == OP_ALU && exu_lsu_rd != 5'd0) begin
                r_wb_vld  <= 1'b1;
                r_wb_addr <= exu_lsu_rd;
                r_wb_data <= exu_lsu_data;
            end else if (r_state == ST_RSP && dmem_lsu_rsp_vld && r_rd != 5'd0) begin
                r_wb_vld  <= 1'b1;
                r_wb_addr <= r_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

    assign lsu_dmem_we    = r_we;
    assign lsu_dmem_addr  = r_addr;
    assign lsu_dmem_wstrb = r_wstrb;
    assign lsu_dmem_wdata = r_wdata;
    assign lsu_rf_wb_vld  = r_wb_vld;
    assign lsu_rf_wb_addr = r_wb_addr;
    assign lsu_rf_wb_data = r_wb_data;

endmodule
`default_nettype wire
